// File: rtl/instruction_memory_responder.sv
// Multi-channel instruction memory with round-robin grant, a LATENCY-deep tagged read
// pipeline and a program-load write port. Define INSTR_MEM_RANGE_CHECK_EN for out-of-range detection.
module instruction_memory_responder #(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_BITS    = 12,
  parameter int DATA_BITS    = 32,
  parameter int LATENCY      = 2,
  parameter int DEPTH        = 4096
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CHANNELS-1:0]           read_valid,
  input  logic [NUM_CHANNELS*ADDR_BITS-1:0] read_address,
  output logic [NUM_CHANNELS-1:0]           read_ready,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] read_data,
  input  logic                              load_valid,
  input  logic [ADDR_BITS-1:0]              load_address,
  input  logic [DATA_BITS-1:0]              load_data,
  output logic                              addr_error
);

  localparam int CH_BITS    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int IDX_BITS   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PIPE_DEPTH = (LATENCY > 1) ? LATENCY - 1 : 1;

  typedef enum logic [1:0] {IDLE, PENDING, RESPOND} ch_state_e;

  ch_state_e            state_q    [NUM_CHANNELS];
  ch_state_e            state_d    [NUM_CHANNELS];
  logic [DATA_BITS-1:0] data_q     [NUM_CHANNELS];
  logic [DATA_BITS-1:0] data_d     [NUM_CHANNELS];
  logic                 pipe_valid_q [PIPE_DEPTH];
  logic                 pipe_valid_d [PIPE_DEPTH];
  logic [CH_BITS-1:0]   pipe_ch_q    [PIPE_DEPTH];
  logic [CH_BITS-1:0]   pipe_ch_d    [PIPE_DEPTH];
  logic [DATA_BITS-1:0] pipe_data_q  [PIPE_DEPTH];
  logic [DATA_BITS-1:0] pipe_data_d  [PIPE_DEPTH];
  logic [CH_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_BITS-1:0] mem [DEPTH];

  logic                 gnt_valid;
  logic [CH_BITS-1:0]   gnt_ch;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [IDX_BITS-1:0]  rd_idx, ld_idx;
  logic [DATA_BITS-1:0] rd_word;
  logic                 ld_en;
  logic                 tap_valid;
  logic [CH_BITS-1:0]   tap_ch;
  logic [DATA_BITS-1:0] tap_data;

  // Round-robin: scan from rr_ptr_q, first IDLE requester wins.
  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin : arb
    int idx;
    gnt_valid = 1'b0;
    gnt_ch    = '0;
    idx       = 0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_CHANNELS;
      if (!gnt_valid && read_valid[idx] && state_q[idx] == IDLE) begin
        gnt_valid = 1'b1;
        gnt_ch    = CH_BITS'(idx);
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (gnt_valid)
      rr_ptr_d = (int'(gnt_ch) == NUM_CHANNELS - 1) ? '0 : gnt_ch + 1'b1;
  end

  // Memory read happens in the grant cycle, so a same-cycle load is not yet visible.
  always_comb begin
    rd_addr = read_address[int'(gnt_ch)*ADDR_BITS +: ADDR_BITS];
    rd_idx  = IDX_BITS'(32'(rd_addr) % 32'(DEPTH));
    ld_idx  = IDX_BITS'(32'(load_address) % 32'(DEPTH));
`ifdef INSTR_MEM_RANGE_CHECK_EN
    rd_word = (32'(rd_addr) >= 32'(DEPTH)) ? '0 : mem[rd_idx];
    ld_en   = load_valid && (32'(load_address) < 32'(DEPTH));
`else
    rd_word = mem[rd_idx];
    ld_en   = load_valid;
`endif
  end

  always_comb begin
    pipe_valid_d[0] = gnt_valid;
    pipe_ch_d[0]    = gnt_ch;
    pipe_data_d[0]  = rd_word;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      pipe_valid_d[k] = pipe_valid_q[k-1];
      pipe_ch_d[k]    = pipe_ch_q[k-1];
      pipe_data_d[k]  = pipe_data_q[k-1];
    end
    if (LATENCY == 1) begin
      tap_valid = gnt_valid;
      tap_ch    = gnt_ch;
      tap_data  = rd_word;
    end else begin
      tap_valid = pipe_valid_q[PIPE_DEPTH-1];
      tap_ch    = pipe_ch_q[PIPE_DEPTH-1];
      tap_data  = pipe_data_q[PIPE_DEPTH-1];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      state_d[i] = state_q[i];
      data_d[i]  = data_q[i];
      case (state_q[i])
        IDLE:    if (gnt_valid && gnt_ch == CH_BITS'(i)) state_d[i] = PENDING;
        PENDING: if (tap_valid && tap_ch == CH_BITS'(i)) begin
                   state_d[i] = RESPOND;
                   data_d[i]  = tap_data;
                 end
        RESPOND: if (!read_valid[i]) state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase
      read_ready[i]                          = (state_q[i] == RESPOND);
      read_data[i*DATA_BITS +: DATA_BITS]    = data_q[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= IDLE;
        data_q[i]  <= '0;
      end
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        pipe_valid_q[k] <= 1'b0;
        pipe_ch_q[k]    <= '0;
        pipe_data_q[k]  <= '0;
      end
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      state_q      <= state_d;
      data_q       <= data_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_ch_q    <= pipe_ch_d;
      pipe_data_q  <= pipe_data_d;
    end
  end

  // NOTE: the storage array has no reset; a loaded program must survive a reset pulse.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= load_data;
  end

`ifdef INSTR_MEM_RANGE_CHECK_EN
  logic addr_error_q, addr_error_d;

  always_comb begin
    addr_error_d = addr_error_q
                 | (gnt_valid  && (32'(rd_addr) >= 32'(DEPTH)))
                 | (load_valid && (32'(load_address) >= 32'(DEPTH)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) addr_error_q <= 1'b0;
    else       addr_error_q <= addr_error_d;
  end

  assign addr_error = addr_error_q;
`else
  assign addr_error = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Scoreboard bench for instruction_memory_responder: expected words and response cycles
// are queued per channel at request time and popped when read_ready rises.
module tb_instruction_memory_responder;

  localparam int NCH = 4;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int DEP = 1024;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NCH-1:0]     read_valid;
  logic [NCH*AW-1:0]  read_address;
  logic [NCH-1:0]     read_ready;
  logic [NCH*DW-1:0]  read_data;
  logic               load_valid;
  logic [AW-1:0]      load_address;
  logic [DW-1:0]      load_data;
  logic               addr_error;

  instruction_memory_responder #(
    .NUM_CHANNELS(NCH), .ADDR_BITS(AW), .DATA_BITS(DW), .LATENCY(LAT), .DEPTH(DEP)
  ) dut (
    .clk(clk), .reset(reset),
    .read_valid(read_valid), .read_address(read_address),
    .read_ready(read_ready), .read_data(read_data),
    .load_valid(load_valid), .load_address(load_address), .load_data(load_data),
    .addr_error(addr_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb [NCH][$];
  logic [DW-1:0] model [DEP];
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rd(input int ch);
    return read_data[ch*DW +: DW];
  endfunction

  // Monitor: pop on each rising read_ready, then require the word to hold while high.
  logic [NCH-1:0] prev_rdy = '0;
  logic [DW-1:0]  held [NCH];
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NCH; i++) begin
      if (read_ready[i] && !prev_rdy[i]) begin
        if (sb[i].size() == 0) begin
          check($sformatf("unexpected_ready_ch%0d", i), 64'(read_ready[i]), 64'd0);
        end else begin
          e = sb[i].pop_front();
          check($sformatf("data_ch%0d", i), 64'(rd(i)), 64'(e.data));
          check($sformatf("latency_ch%0d", i), 64'(cyc), 64'(e.due));
        end
        held[i] = rd(i);
      end else if (read_ready[i] && prev_rdy[i]) begin
        check($sformatf("hold_ch%0d", i), 64'(rd(i)), 64'(held[i]));
      end
    end
    prev_rdy = read_ready;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic load(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    load_valid   = 1'b1;
    load_address = addr;
    load_data    = data;
    model[int'(addr) % DEP] = data;
    step();
    load_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] expect_word(input logic [AW-1:0] addr);
`ifdef INSTR_MEM_RANGE_CHECK_EN
    if (int'(addr) >= DEP) return '0;
`endif
    return model[int'(addr) % DEP];
  endfunction

  task automatic req(input int ch, input logic [AW-1:0] addr, input int extra_wait);
    exp_t e;
    read_valid[ch]             = 1'b1;
    read_address[ch*AW +: AW] = addr;
    e.data = expect_word(addr);
    e.due  = cyc + LAT + extra_wait;
    sb[ch].push_back(e);
  endtask

  task automatic fetch(input int ch, input logic [AW-1:0] addr, input int hold);
    req(ch, addr, 0);
    steps(hold);
    read_valid[ch] = 1'b0;
    steps(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int order_wait [NCH];
    read_valid   = '0;
    read_address = '0;
    load_valid   = 1'b0;
    load_address = '0;
    load_data    = '0;

    // Reset state
    steps(3);
    check("reset_ready", 64'(read_ready), 64'd0);
    check("reset_data",  64'(read_data[63:0]), 64'd0);
    check("reset_data_hi", 64'(read_data[127:64]), 64'd0);
    check("reset_addr_error", 64'(addr_error), 64'd0);
    reset = 1'b0;
    step();

    // Program load
    for (int i = 0; i < NCH; i++) load(AW'(i), 32'hA5A5_0000 + 32'(i));
    load(12'h010, 32'hDEAD_BEEF);
    load(12'h020, 32'h2222_2222);
    load(12'h030, 32'h3333_3333);

    // All four channels at once from pointer 0: grants 0,1,2,3 back to back
    for (int i = 0; i < NCH; i++) req(i, AW'(i), i);
    steps(6);
    check("all_ready", 64'(read_ready), 64'hF);
    read_valid = '0;
    step();
    check("all_dropped", 64'(read_ready), 64'h0);
    step();

    // Single read with hold, data retained after ready drops
    fetch(0, 12'h010, 4);
    check("ch0_ready_low", 64'(read_ready[0]), 64'd0);
    check("ch0_data_kept", 64'(rd(0)), 64'hDEAD_BEEF);

    // Same-cycle load and read of one address returns the old word
    req(1, 12'h020, 0);
    load(12'h020, 32'h1111_1111);
    steps(2);
    read_valid[1] = 1'b0;
    steps(2);
    fetch(1, 12'h020, 3);

    // Valid dropped while pending: access completes with a one-cycle ready
    req(0, 12'h001, 0);
    step();
    read_valid[0] = 1'b0;
    step();
    check("cancel_ready_hi", 64'(read_ready[0]), 64'd1);
    step();
    check("cancel_ready_lo", 64'(read_ready[0]), 64'd0);

    // Held valid keeps ready up without re-grant; new request accepted after the drop
    req(3, 12'h003, 0);
    steps(2);
    for (int k = 0; k < 5; k++) begin
      check("ch3_held_ready", 64'(read_ready[3]), 64'd1);
      step();
    end
    read_valid[3] = 1'b0;
    step();
    check("ch3_ready_low", 64'(read_ready[3]), 64'd0);
    check("ch3_data_kept", 64'(rd(3)), 64'hA5A5_0003);
    req(3, 12'h002, 0);
    steps(3);
    read_valid[3] = 1'b0;
    steps(2);

    // Reset one cycle after a ch2 grant discards the in-flight response
    read_valid[2]           = 1'b1;
    read_address[2*AW +: AW] = 12'h030;
    step();
    reset = 1'b1;
    #1;
    check("midreset_ready", 64'(read_ready), 64'd0);
    check("midreset_data",  64'(read_data[127:64]), 64'd0);
    steps(2);
    read_valid[2] = 1'b0;
    reset = 1'b0;
    steps(6);
    check("post_reset_ready", 64'(read_ready), 64'd0);
    fetch(2, 12'h030, 3);

    // Round-robin from pointer 3 (ch2 was last granted): order 3,0,1,2
    order_wait[3] = 0; order_wait[0] = 1; order_wait[1] = 2; order_wait[2] = 3;
    req(0, 12'h010, order_wait[0]);
    req(1, 12'h001, order_wait[1]);
    req(2, 12'h002, order_wait[2]);
    req(3, 12'h020, order_wait[3]);
    steps(6);
    check("rr_all_ready", 64'(read_ready), 64'hF);
    read_valid = '0;
    steps(2);

    // Address beyond DEPTH
    fetch(0, 12'h400, 3);
`ifdef INSTR_MEM_RANGE_CHECK_EN
    check("oob_addr_error", 64'(addr_error), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("oob_error_cleared", 64'(addr_error), 64'd0);
`else
    check("wrap_addr_error", 64'(addr_error), 64'd0);
`endif

    steps(3);
    for (int i = 0; i < NCH; i++)
      check($sformatf("sb_empty_ch%0d", i), 64'(sb[i].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
